// File: rtl/regbank_pkg.sv
// Shared sizing constants and types for the ARM64 architectural register bank.
package regbank_pkg;

  localparam int WIDTH = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  localparam logic [AW-1:0] XZR_IDX = 5'd31;
  localparam logic [15:0]   CNT_MAX = 16'hFFFF;

  typedef logic [WIDTH-1:0] word_t;

  function automatic logic is_xzr(input logic [AW-1:0] addr);
    return (addr == XZR_IDX);
  endfunction

endpackage

// File: rtl/regbank_wr_demux_dec.sv
// Write-address decode: dec2x4 and dec3x8 leaf decoders composed into dec5x32.
module dec2x4 (
  input  logic       i_en,
  input  logic [1:0] i_a,
  output logic [3:0] o_y
);

  // One-hot select of the 8-register group, forced low while disabled
  always_comb begin
    o_y = 4'b0000;
    if (i_en) begin
      case (i_a)
        2'd0:    o_y = 4'b0001;
        2'd1:    o_y = 4'b0010;
        2'd2:    o_y = 4'b0100;
        2'd3:    o_y = 4'b1000;
        default: o_y = 4'b0000;
      endcase
    end else begin
      o_y = 4'b0000;
    end
  end

endmodule

module dec3x8 (
  input  logic       i_en,
  input  logic [2:0] i_a,
  output logic [7:0] o_y
);

  // One-hot select within a group of eight registers
  always_comb begin
    o_y = 8'b0000_0000;
    if (i_en) begin
      case (i_a)
        3'd0:    o_y = 8'b0000_0001;
        3'd1:    o_y = 8'b0000_0010;
        3'd2:    o_y = 8'b0000_0100;
        3'd3:    o_y = 8'b0000_1000;
        3'd4:    o_y = 8'b0001_0000;
        3'd5:    o_y = 8'b0010_0000;
        3'd6:    o_y = 8'b0100_0000;
        3'd7:    o_y = 8'b1000_0000;
        default: o_y = 8'b0000_0000;
      endcase
    end else begin
      o_y = 8'b0000_0000;
    end
  end

endmodule

module dec5x32 (
  input  logic        i_en,
  input  logic [4:0]  i_a,
  output logic [31:0] o_y
);

  logic [3:0] w_grp;

  dec2x4 u_dec_hi (
    .i_en (i_en),
    .i_a  (i_a[4:3]),
    .o_y  (w_grp)
  );

  // The enable gates the first stage, so an unknown address never reaches the leaves
  for (genvar gk = 0; gk < 4; gk++) begin : g_leaf
    dec3x8 u_dec_lo (
      .i_en (w_grp[gk]),
      .i_a  (i_a[2:0]),
      .o_y  (o_y[gk*8 +: 8])
    );
  end

endmodule

// File: rtl/regbank_wr_demux.sv
// Register bank write demux with registered debug read port and write ack/count.
// Optional build macro REGBANK_WR_BYPASS_EN: debug read returns same-cycle write data.
module regbank_wr_demux
  import regbank_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [NREGS*WIDTH-1:0] bank_q,
  input  logic [AW-1:0]          dbg_addr,
  output logic [WIDTH-1:0]       dbg_data,
  output logic                   wr_ack,
  output logic [15:0]            wr_count
);

  logic [NREGS-1:0] w_onehot;
  logic [NREGS-1:0] w_load;
  logic             w_accept;
  word_t            w_word [NREGS];
  word_t            w_dbg_rd;
  word_t            w_dbg_nxt;

  word_t            r_dbg;
  logic             r_ack;
  logic [15:0]      r_count;

  dec5x32 u_wr_dec (
    .i_en (wr_en),
    .i_a  (wr_addr),
    .o_y  (w_onehot)
  );

  // XZR has no storage: its enable is dropped so it neither loads nor acks
  assign w_load   = {1'b0, w_onehot[NREGS-2:0]};
  assign w_accept = |w_load;

  for (genvar gi = 0; gi < NREGS - 1; gi++) begin : g_reg
    word_t r_reg;

    // Per-register hold/load select driven by its one-hot enable
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_reg <= '0;
      end else if (w_load[gi]) begin
        r_reg <= wr_data;
      end else begin
        r_reg <= r_reg;
      end
    end

    assign w_word[gi]                  = r_reg;
    assign bank_q[gi*WIDTH +: WIDTH]   = r_reg;
  end

  assign w_word[NREGS-1]                   = '0;
  assign bank_q[(NREGS-1)*WIDTH +: WIDTH]  = '0;

  for (genvar gb = 0; gb < WIDTH; gb++) begin : g_dbg_mux
    logic [NREGS-1:0] w_col;

    // Gather bit gb of every register into one 32:1 mux column
    always_comb begin
      w_col = '0;
      for (int i = 0; i < NREGS; i++) begin
        w_col[i] = w_word[i][gb];
      end
    end

    assign w_dbg_rd[gb] = w_col[dbg_addr];
  end

  // Debug capture source: stored value, or write-through when enabled
  always_comb begin
    w_dbg_nxt = w_dbg_rd;
`ifdef REGBANK_WR_BYPASS_EN
    if (w_accept && (dbg_addr == wr_addr) && !is_xzr(dbg_addr)) begin
      w_dbg_nxt = wr_data;
    end else begin
      w_dbg_nxt = w_dbg_rd;
    end
`else
    w_dbg_nxt = w_dbg_rd;
`endif
  end

  // Debug read register, write ack pulse and saturating accepted-write counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dbg   <= '0;
      r_ack   <= 1'b0;
      r_count <= 16'h0000;
    end else begin
      r_dbg <= w_dbg_nxt;
      r_ack <= w_accept;
      if (w_accept && (r_count != CNT_MAX)) begin
        r_count <= r_count + 16'h0001;
      end else begin
        r_count <= r_count;
      end
    end
  end

  assign dbg_data = r_dbg;
  assign wr_ack   = r_ack;
  assign wr_count = r_count;

endmodule
